// File: rtl/sram_bus_arbiter_pkg.sv
// Shared encodings for the SRAM-like bus arbiter: FSM states, owner ids,
// transfer sizes and the master-side request record.
package sram_bus_arbiter_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mreq_t;
endpackage

// File: rtl/sram_bus_arbiter_if.sv
// Client (fetch/data) and master-port signals of the arbiter in one bundle.
interface sram_bus_arbiter_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  logic        m_req;
  logic        m_wr;
  logic [1:0]  m_size;
  logic [3:0]  m_wstrb;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_addr_ok;
  logic        m_data_ok;
  logic [31:0] m_rdata;

  // Arbiter view
  modport master (
    input  inst_req, inst_addr,
    input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    input  m_addr_ok, m_data_ok, m_rdata,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output m_req, m_wr, m_size, m_wstrb, m_addr, m_wdata
  );

  // Environment view (clients + SRAM slave)
  modport slave (
    output inst_req, inst_addr,
    output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    output m_addr_ok, m_data_ok, m_rdata,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  m_req, m_wr, m_size, m_wstrb, m_addr, m_wdata
  );
endinterface

// File: rtl/sram_bus_arbiter_prio_pick.sv
// Combinational grant decision between fetch and data clients.
module arb_prio_pick
  import sram_bus_arbiter_pkg::*;
#(
  parameter bit DATA_PRIO = 1'b1
) (
  input  logic   inst_req,
  input  logic   data_req,
  input  logic   streak_full,
  output logic   grant,
  output owner_e owner
);
  always_comb begin
    grant = inst_req | data_req;
    owner = OWN_INST;
    if (inst_req && data_req) begin
      // A full data streak forces the fetch through regardless of priority.
      if (!streak_full && DATA_PRIO) owner = OWN_DATA;
    end else if (data_req) begin
      owner = OWN_DATA;
    end
  end
endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like master port between fetch and data clients,
// one outstanding transaction at a time, with bounded data streaks.
module sram_bus_arbiter
  import sram_bus_arbiter_pkg::*;
#(
  parameter bit          DATA_PRIO  = 1'b1,
  parameter int unsigned MAX_STREAK = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sram_bus_arbiter_if.master   bus,
  output logic                 busy
);
  localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

  state_e     state_q, state_d;
  owner_e     owner_q, owner_d;
  logic [3:0] streak_q, streak_d;

  logic   grant;
  owner_e pick;
  mreq_t  inst_f, data_f, sel_f;

  arb_prio_pick #(.DATA_PRIO(DATA_PRIO)) u_pick (
    .inst_req    (bus.inst_req),
    .data_req    (bus.data_req),
    .streak_full (streak_q == STREAK_MAX),
    .grant       (grant),
    .owner       (pick)
  );

  always_comb begin
    inst_f = '{wr: 1'b0, size: SZ_WORD, wstrb: 4'h0, addr: bus.inst_addr, wdata: 32'h0};
    data_f = '{wr: bus.data_wr, size: bus.data_size, wstrb: bus.data_wstrb,
               addr: bus.data_addr, wdata: bus.data_wdata};
    sel_f  = (owner_q == OWN_DATA) ? data_f : inst_f;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      owner_q  <= OWN_INST;
      streak_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      streak_q <= streak_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    streak_d = streak_q;

    bus.m_req   = 1'b0;
    bus.m_wr    = 1'b0;
    bus.m_size  = 2'd0;
    bus.m_wstrb = 4'h0;
    bus.m_addr  = 32'h0;
    bus.m_wdata = 32'h0;

    bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b0;
    bus.inst_rdata   = 32'h0;
    bus.data_addr_ok = 1'b0;
    bus.data_data_ok = 1'b0;
    bus.data_rdata   = 32'h0;

    unique case (state_q)
      ST_IDLE: begin
        if (grant) begin
          owner_d = pick;
          state_d = ST_ADDR;
          // Only data grants that leave a fetch waiting extend the streak.
          if (pick == OWN_DATA && bus.inst_req)
            streak_d = (streak_q >= STREAK_MAX) ? STREAK_MAX : streak_q + 4'd1;
          else
            streak_d = 4'd0;
        end
      end
      ST_ADDR: begin
        bus.m_req   = 1'b1;
        bus.m_wr    = sel_f.wr;
        bus.m_size  = sel_f.size;
        bus.m_wstrb = sel_f.wstrb;
        bus.m_addr  = sel_f.addr;
        bus.m_wdata = sel_f.wdata;
        if (bus.m_addr_ok) begin
          bus.inst_addr_ok = (owner_q == OWN_INST);
          bus.data_addr_ok = (owner_q == OWN_DATA);
          state_d          = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bus.m_data_ok) begin
          if (owner_q == OWN_DATA) begin
            bus.data_data_ok = 1'b1;
            bus.data_rdata   = bus.m_rdata;
          end else begin
            bus.inst_data_ok = 1'b1;
            bus.inst_rdata   = bus.m_rdata;
          end
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q != ST_IDLE);
endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Self-checking bench for sram_bus_arbiter: directed table, corner-case
// sequences and a randomized run against a transaction-level model.
module tb_sram_bus_arbiter;
  localparam bit DP = 1'b1;
  localparam int MS = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;

  sram_bus_arbiter_if bus ();

  sram_bus_arbiter #(.DATA_PRIO(DP), .MAX_STREAK(MS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic ia, id; logic [31:0] ir;
    logic da, dd; logic [31:0] dr;
    logic mreq, mwr; logic [1:0] msz; logic [3:0] mstb;
    logic [31:0] maddr, mwdata;
    logic busy;
  } outs_t;

  typedef struct packed {
    logic ireq; logic [31:0] iaddr;
    logic dreq, dwr; logic [1:0] dsz; logic [3:0] dstb;
    logic [31:0] daddr, dwdata;
    logic maok, mdok; logic [31:0] mrdata;
  } in_t;

  typedef struct packed { in_t i; outs_t e; } vec_t;

  outs_t obs;

  function automatic outs_t sample();
    outs_t o;
    o.ia = bus.inst_addr_ok; o.id = bus.inst_data_ok; o.ir = bus.inst_rdata;
    o.da = bus.data_addr_ok; o.dd = bus.data_data_ok; o.dr = bus.data_rdata;
    o.mreq = bus.m_req; o.mwr = bus.m_wr; o.msz = bus.m_size; o.mstb = bus.m_wstrb;
    o.maddr = bus.m_addr; o.mwdata = bus.m_wdata; o.busy = busy;
    return o;
  endfunction

  function automatic string fmt(outs_t o);
    return $sformatf("ia=%b id=%b ir=%h da=%b dd=%b dr=%h req=%b wr=%b sz=%0d stb=%h a=%h wd=%h busy=%b",
      o.ia, o.id, o.ir, o.da, o.dd, o.dr, o.mreq, o.mwr, o.msz, o.mstb, o.maddr, o.mwdata, o.busy);
  endfunction

  task automatic chk(input string name, input outs_t act, input outs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got {%s} want {%s}", name, fmt(act), fmt(exp));
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Transaction-level reference: who owns the current transfer, whether its
  // address was taken, and the fields captured when it was granted.
  int          cur_own = -1;
  bit          cur_acc;
  int          streak = 0;
  logic        cur_wr;
  logic [1:0]  cur_sz;
  logic [3:0]  cur_stb;
  logic [31:0] cur_addr, cur_wdata;

  task automatic model_step(output outs_t e);
    bit take_data;
    e = '0;
    if (cur_own < 0) begin
      if (bus.inst_req || bus.data_req) begin
        if (bus.inst_req && bus.data_req) take_data = (streak >= MS) ? 1'b0 : DP;
        else take_data = bus.data_req;
        if (take_data && bus.inst_req) streak = (streak + 1 < MS) ? streak + 1 : MS;
        else streak = 0;
        cur_own = take_data ? 1 : 0;
        cur_acc = 1'b0;
        if (take_data) begin
          cur_wr = bus.data_wr; cur_sz = bus.data_size; cur_stb = bus.data_wstrb;
          cur_addr = bus.data_addr; cur_wdata = bus.data_wdata;
        end else begin
          cur_wr = 1'b0; cur_sz = 2'd2; cur_stb = 4'h0;
          cur_addr = bus.inst_addr; cur_wdata = 32'h0;
        end
      end
    end else if (!cur_acc) begin
      e.busy = 1'b1; e.mreq = 1'b1;
      e.mwr = cur_wr; e.msz = cur_sz; e.mstb = cur_stb; e.maddr = cur_addr; e.mwdata = cur_wdata;
      if (bus.m_addr_ok) begin
        if (cur_own == 1) e.da = 1'b1; else e.ia = 1'b1;
        cur_acc = 1'b1;
      end
    end else begin
      e.busy = 1'b1;
      if (bus.m_data_ok) begin
        if (cur_own == 1) begin e.dd = 1'b1; e.dr = bus.m_rdata; end
        else begin e.id = 1'b1; e.ir = bus.m_rdata; end
        cur_own = -1;
      end
    end
  endtask

  task automatic tick(input string name);
    outs_t e;
    @(negedge clk);
    model_step(e);
    obs = sample();
    chk(name, obs, e);
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    bus.inst_req = 1'b0; bus.inst_addr = 32'h0;
    bus.data_req = 1'b0; bus.data_wr = 1'b0; bus.data_size = 2'd0; bus.data_wstrb = 4'h0;
    bus.data_addr = 32'h0; bus.data_wdata = 32'h0;
    bus.m_addr_ok = 1'b0; bus.m_data_ok = 1'b0; bus.m_rdata = 32'h0;
  endtask

  task automatic drive(input in_t i);
    bus.inst_req = i.ireq; bus.inst_addr = i.iaddr;
    bus.data_req = i.dreq; bus.data_wr = i.dwr; bus.data_size = i.dsz; bus.data_wstrb = i.dstb;
    bus.data_addr = i.daddr; bus.data_wdata = i.dwdata;
    bus.m_addr_ok = i.maok; bus.m_data_ok = i.mdok; bus.m_rdata = i.mrdata;
  endtask

  function automatic in_t mk_in(logic ireq, logic [31:0] iaddr, logic dreq, logic dwr,
                                logic [1:0] dsz, logic [3:0] dstb, logic [31:0] daddr,
                                logic [31:0] dwdata, logic maok, logic mdok, logic [31:0] mrdata);
    return '{ireq, iaddr, dreq, dwr, dsz, dstb, daddr, dwdata, maok, mdok, mrdata};
  endfunction

  function automatic outs_t mk_out(logic ia, logic id, logic [31:0] ir, logic da, logic dd,
                                   logic [31:0] dr, logic mreq, logic mwr, logic [1:0] msz,
                                   logic [3:0] mstb, logic [31:0] maddr, logic [31:0] mwdata,
                                   logic b);
    return '{ia, id, ir, da, dd, dr, mreq, mwr, msz, mstb, maddr, mwdata, b};
  endfunction

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  tbl [10];
    string seq;
    int    n, lat;
    bit    pend, done;
    localparam logic [31:0] IA0 = 32'hBFC00000, IA1 = 32'hBFC00004, DA = 32'h80000010;

    // Fetch, then simultaneous store+fetch where the store wins.
    tbl[0] = '{mk_in(1'b1, IA0, 1'b0, 1'b0, 2'd0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0), '0};
    tbl[1] = '{mk_in(1'b1, IA0, 1'b0, 1'b0, 2'd0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0),
               mk_out(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 2'd2, 4'h0, IA0, 32'h0, 1'b1)};
    tbl[2] = '{mk_in(1'b0, IA0, 1'b0, 1'b0, 2'd0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h3C08BFAF),
               mk_out(1'b0, 1'b1, 32'h3C08BFAF, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 4'h0, 32'h0, 32'h0, 1'b1)};
    tbl[3] = '{mk_in(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0), '0};
    tbl[4] = '{mk_in(1'b1, IA1, 1'b1, 1'b1, 2'd1, 4'h3, DA, 32'h1234, 1'b0, 1'b0, 32'h0), '0};
    tbl[5] = '{mk_in(1'b1, IA1, 1'b1, 1'b1, 2'd1, 4'h3, DA, 32'h1234, 1'b1, 1'b0, 32'h0),
               mk_out(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 2'd1, 4'h3, DA, 32'h1234, 1'b1)};
    tbl[6] = '{mk_in(1'b1, IA1, 1'b0, 1'b0, 2'd0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0),
               mk_out(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 2'd0, 4'h0, 32'h0, 32'h0, 1'b1)};
    tbl[7] = '{mk_in(1'b1, IA1, 1'b0, 1'b0, 2'd0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0), '0};
    tbl[8] = '{mk_in(1'b1, IA1, 1'b0, 1'b0, 2'd0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0),
               mk_out(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 2'd2, 4'h0, IA1, 32'h0, 1'b1)};
    tbl[9] = '{mk_in(1'b0, IA1, 1'b0, 1'b0, 2'd0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF),
               mk_out(1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 4'h0, 32'h0, 32'h0, 1'b1)};

    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    chk("reset_outputs", sample(), '0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int k = 0; k < 10; k++) begin
      drive(tbl[k].i);
      tick($sformatf("vec%0d_model", k));
      chk($sformatf("vec%0d", k), obs, tbl[k].e);
    end
    idle_inputs();

    // Starvation guard: continuous loads with a waiting fetch.
    bus.inst_req = 1'b1; bus.inst_addr = 32'hBFC00100;
    bus.data_req = 1'b1; bus.data_size = 2'd2; bus.data_addr = 32'h80001000;
    bus.m_addr_ok = 1'b1;
    seq = ""; n = 0; pend = 1'b0;
    for (int c = 0; c < 60 && n < 6; c++) begin
      bus.m_data_ok = pend; bus.m_rdata = $urandom;
      tick("starve");
      if (obs.ia) begin seq = {seq, "I"}; n++; bus.inst_req = 1'b0; pend = 1'b1; end
      if (obs.da) begin seq = {seq, "D"}; n++; bus.data_addr += 32'd4; pend = 1'b1; end
      if (obs.id || obs.dd) pend = 1'b0;
    end
    checks++;
    if (seq != "DDDDID") begin
      errors++;
      $display("FAIL starve_order: got %s want DDDDID", seq);
    end
    bus.data_req = 1'b0; bus.m_addr_ok = 1'b0; bus.m_data_ok = 1'b1;
    tick("starve_drain");
    idle_inputs();
    tick("starve_idle");

    // Slave backpressure: address phase held while the fetch shows up.
    bus.data_req = 1'b1; bus.data_size = 2'd2; bus.data_addr = 32'h80000100;
    tick("bp_grant");
    for (int k = 0; k < 5; k++) begin
      if (k == 1) begin bus.inst_req = 1'b1; bus.inst_addr = 32'hBFC00200; end
      tick("bp_wait");
      chk32("bp_addr_stable", obs.maddr, 32'h80000100);
      chk32("bp_no_addr_ok", {30'h0, obs.ia, obs.da}, 32'h0);
    end
    bus.m_addr_ok = 1'b1;
    tick("bp_accept");
    chk32("bp_owner_data", {31'h0, obs.da}, 32'h1);
    bus.data_req = 1'b0; bus.m_addr_ok = 1'b0; bus.m_data_ok = 1'b1; bus.m_rdata = 32'h0BADF00D;
    tick("bp_data");
    bus.m_data_ok = 1'b0;
    tick("bp_inst_grant");
    bus.m_addr_ok = 1'b1;
    tick("bp_inst_addr");
    chk32("bp_inst_addr_ok", {31'h0, obs.ia}, 32'h1);
    bus.inst_req = 1'b0; bus.m_addr_ok = 1'b0; bus.m_data_ok = 1'b1;
    tick("bp_inst_data");
    idle_inputs();

    // Isolation: a data response never leaks onto the fetch side.
    bus.data_req = 1'b1; bus.data_size = 2'd2; bus.data_addr = 32'h80000200;
    tick("iso_grant");
    bus.m_addr_ok = 1'b1;
    tick("iso_addr");
    bus.data_req = 1'b0; bus.m_addr_ok = 1'b0; bus.m_data_ok = 1'b1; bus.m_rdata = 32'hCAFEF00D;
    tick("iso_data");
    chk32("iso_inst_data_ok", {31'h0, obs.id}, 32'h0);
    chk32("iso_inst_rdata", obs.ir, 32'h0);
    chk32("iso_data_rdata", obs.dr, 32'hCAFEF00D);
    idle_inputs();

    // Reset while waiting for data: outputs clear at once, stale data_ok dropped.
    bus.data_req = 1'b1; bus.data_size = 2'd2; bus.data_addr = 32'h80000300;
    tick("rst_grant");
    bus.m_addr_ok = 1'b1;
    tick("rst_addr");
    bus.data_req = 1'b0; bus.m_addr_ok = 1'b0;
    tick("rst_wait");
    rst_n = 1'b0; bus.m_data_ok = 1'b1;
    #1;
    chk("rst_async", sample(), '0);
    cur_own = -1; streak = 0;
    tick("rst_hold");
    rst_n = 1'b1;
    tick("rst_stale_data_ok");
    bus.m_data_ok = 1'b0;
    bus.inst_req = 1'b1; bus.inst_addr = 32'hBFC00300; bus.m_addr_ok = 1'b1;
    lat = 0; done = 1'b0; pend = 1'b0;
    for (int c = 1; c <= 10 && !done; c++) begin
      bus.m_data_ok = pend;
      tick("rst_next");
      if (obs.ia) begin bus.inst_req = 1'b0; pend = 1'b1; end
      if (obs.id) begin done = 1'b1; lat = c; pend = 1'b0; end
    end
    chk32("rst_latency", 32'(lat), 32'd3);
    idle_inputs();

    // Randomized clients and slave against the transaction model.
    pend = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if (!bus.inst_req && $urandom_range(0, 2) == 0) begin
        bus.inst_req = 1'b1; bus.inst_addr = $urandom & 32'hFFFFFFFC;
      end
      if (!bus.data_req && $urandom_range(0, 2) == 0) begin
        bus.data_req = 1'b1; bus.data_wr = 1'($urandom_range(0, 1));
        bus.data_size = 2'($urandom_range(0, 2)); bus.data_wstrb = 4'($urandom);
        bus.data_addr = $urandom; bus.data_wdata = $urandom;
      end
      bus.m_addr_ok = 1'($urandom_range(0, 1));
      bus.m_data_ok = pend && ($urandom_range(0, 2) != 0);
      bus.m_rdata = $urandom;
      tick("rand");
      if (obs.ia) bus.inst_req = 1'b0;
      if (obs.da) bus.data_req = 1'b0;
      if (obs.mreq && bus.m_addr_ok) pend = 1'b1;
      else if (bus.m_data_ok) pend = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
